game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer. It replaces the switch-driven next-state debug logic in the game top. It walks the match through IDLE, INTRO, PvP or PvAI, and GAME_OVER from debounced button pulses, per-frame timing and round-end events from the player datapath. It keeps the round score and the winner, and issues round-restart pulses to the player/physics logic.

Parameters:
INTRO_TICKS, 150, frames spent in INTRO before play starts (2.5 s at 60 Hz)
OVER_TICKS, 300, frames GAME_OVER is held before the automatic return to IDLE
WIN_ROUNDS, 3, round wins needed to take the match; legal range 1..3 (2-bit score)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per video frame
btn_start  in  1  one-cycle debounced press pulse
btn_mode  in  1  one-cycle debounced press pulse; toggles PvP/PvAI selection
p1_out  in  1  one-cycle pulse: player 1 lost the current round
p2_out  in  1  one-cycle pulse: player 2 lost the current round
game_state  out  3  IDLE=0, INTRO=1, PvP=2, PvAI=3, GAME_OVER=4
mode_ai  out  1  1 = PvAI selected
state_enter  out  1  high on the first cycle of each new state
round_reset  out  1  one-cycle pulse: respawn players
round_active  out  1  high in PvP/PvAI
p1_score  out  2  rounds won by player 1
p2_score  out  2  rounds won by player 2
winner  out  2  0 = none, 1 = P1, 2 = P2

Behaviour:
- Reset is synchronous and active-high, and overrides all other inputs.
- Reset values: game_state=IDLE, mode_ai=0, scores=0, winner=0, state_enter=0, round_reset=0, frame timer=0.
- All outputs are registered. game_state changes on the clock edge after the triggering input is sampled.
- state_enter and round_reset are high for exactly one cycle.
- Frame timer clears whenever the state changes and increments on frame_tick. It is sized to cover max(INTRO_TICKS, OVER_TICKS).
- IDLE:
  - btn_mode toggles mode_ai. mode_ai is frozen in every other state.
  - btn_start clears scores and winner, then enters INTRO.
  - btn_start and btn_mode in the same cycle: start wins and mode_ai does not toggle.
- INTRO:
  - Moves to PvAI if mode_ai=1, else PvP, on a frame_tick with timer == INTRO_TICKS-1.
  - btn_start skips the intro with the same destination.
  - Both events in the same cycle cause exactly one transition.
- Entry to PvP/PvAI asserts round_reset in the same cycle as state_enter.
- PvP/PvAI, round-end events:
  - p1_out alone increments p2_score.
  - p2_out alone increments p1_score.
  - p1_out and p2_out together: draw, no score change, round_reset next cycle.
- PvP/PvAI, after a scoring event:
  - If the new score equals WIN_ROUNDS: next cycle enter GAME_OVER and set winner (1 or 2). No round_reset.
  - Otherwise: round_reset pulses the next cycle and the state is unchanged.
- btn_start and btn_mode are ignored in PvP/PvAI.
- GAME_OVER:
  - Scores and winner hold their values.
  - Returns to IDLE on a frame_tick with timer == OVER_TICKS-1, or on btn_start.
  - On return, mode_ai is kept; scores and winner are cleared only by the next start.
- p1_out and p2_out are ignored outside PvP/PvAI.
- round_active = (game_state==PvP) or (game_state==PvAI).
- Illegal game_state encodings (5..7) go to IDLE on the next cycle with state_enter asserted.
- Reset asserted mid-match aborts immediately to the reset values above. No GAME_OVER is shown.

Decomposition:
- game_pkg holds the state encodings (S_IDLE..S_GAME_OVER), the winner encodings (W_NONE, W_P1, W_P2) and the 3-bit state width. It is shared with the game top and the HEX/LED display logic.
- One sub-module, frame_timer: a tick counter with clear, count and terminal-compare-to-limit. It is instantiated once and its limit is muxed between INTRO_TICKS and OVER_TICKS by state.

Test Plan:
- Reset, then btn_mode ×3, then btn_start → mode_ai=1; INTRO with state_enter=1. After 150 frame_ticks → game_state=3 and round_reset=1 in the same cycle.
- PvP with INTRO skipped by a second btn_start: p2_out ×3 one frame apart → p1_score 1,2,3. round_reset after the first two only. GAME_OVER with winner=1 the cycle after the third.
- In PvP, p1_out and p2_out in the same cycle → scores unchanged, round_reset=1 next cycle, state stays 2.
- GAME_OVER with no input → IDLE after exactly 300 frame_ticks. A separate run with btn_start → IDLE next cycle; mode_ai unchanged.
- btn_start and btn_mode together in IDLE → INTRO, mode_ai not toggled. btn_mode during PvAI → mode_ai stays 1.
- Reset asserted mid-PvAI with p1_score=2 → next cycle all outputs at reset values. p1_out pulses in IDLE → scores stay 0.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared game state / winner encodings for the flow controller and
//            the display logic.
// Revision : 1.0
// ============================================================================
package game_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_INTRO     = 3'd1;
    localparam logic [STATE_W-1:0] S_PVP       = 3'd2;
    localparam logic [STATE_W-1:0] S_PVAI      = 3'd3;
    localparam logic [STATE_W-1:0] S_GAME_OVER = 3'd4;

    typedef enum logic [1:0] {
        W_NONE = 2'd0,
        W_P1   = 2'd1,
        W_P2   = 2'd2
    } winner_e;

    function automatic logic is_play_state(input logic [STATE_W-1:0] s);
        return (s == S_PVP) || (s == S_PVAI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl_if
// Brief    : Event inputs and match status outputs of the game sequencer.
// Revision : 1.0
// ============================================================================
interface game_flow_ctrl_if;
    import game_pkg::*;

    logic               frame_tick;
    logic               btn_start;
    logic               btn_mode;
    logic               p1_out;
    logic               p2_out;
    logic [STATE_W-1:0] game_state;
    logic               mode_ai;
    logic               state_enter;
    logic               round_reset;
    logic               round_active;
    logic [1:0]         p1_score;
    logic [1:0]         p2_score;
    logic [1:0]         winner;

    modport master (
        output frame_tick, btn_start, btn_mode, p1_out, p2_out,
        input  game_state, mode_ai, state_enter, round_reset, round_active,
               p1_score, p2_score, winner
    );

    modport slave (
        input  frame_tick, btn_start, btn_mode, p1_out, p2_out,
        output game_state, mode_ai, state_enter, round_reset, round_active,
               p1_score, p2_score, winner
    );

endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timer
// Brief    : Frame tick counter with clear and terminal-count detect.
// Revision : 1.0
// ============================================================================
module frame_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (tick_i) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    // Terminal tick: the limit-th tick counted since the last clear.
    assign done_o = tick_i && (count_q == (limit_i - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl
// Brief    : Match sequencer: IDLE -> INTRO -> PvP/PvAI -> GAME_OVER, scoring
//            and round-restart pulses.
// Revision : 1.0
// ============================================================================
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int INTRO_TICKS = 150,
    parameter int OVER_TICKS  = 300,
    parameter int WIN_ROUNDS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    game_flow_ctrl_if.slave  bus
);

    localparam int c_MAX_TICKS = (INTRO_TICKS > OVER_TICKS) ? INTRO_TICKS : OVER_TICKS;
    localparam int c_TIMER_W   = $clog2(c_MAX_TICKS + 1);
    localparam logic [c_TIMER_W-1:0] c_INTRO_LIM = c_TIMER_W'(INTRO_TICKS);
    localparam logic [c_TIMER_W-1:0] c_OVER_LIM  = c_TIMER_W'(OVER_TICKS);
    localparam logic [1:0]           c_WIN       = 2'(WIN_ROUNDS);

    logic [STATE_W-1:0] state_q, state_d;
    logic               mode_ai_q, mode_ai_d;
    logic [1:0]         p1_score_q, p1_score_d;
    logic [1:0]         p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               state_enter_q, state_enter_d;
    logic               round_reset_q, round_reset_d;
    logic               round_active_q;

    logic                 w_timer_done;
    logic [c_TIMER_W-1:0] w_timer_limit;
    logic [1:0]           w_p1_inc;
    logic [1:0]           w_p2_inc;

    assign w_timer_limit = (state_q == S_INTRO) ? c_INTRO_LIM : c_OVER_LIM;
    assign w_p1_inc      = p1_score_q + 2'd1;
    assign w_p2_inc      = p2_score_q + 2'd1;

    frame_timer #(
        .WIDTH (c_TIMER_W)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (reset),
        .clr_i   (state_d != state_q),
        .tick_i  (bus.frame_tick),
        .limit_i (w_timer_limit),
        .done_o  (w_timer_done)
    );

    always_comb begin
        state_d       = state_q;
        mode_ai_d     = mode_ai_q;
        p1_score_d    = p1_score_q;
        p2_score_d    = p2_score_q;
        winner_d      = winner_q;
        round_reset_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.btn_start) begin
                    p1_score_d = 2'd0;
                    p2_score_d = 2'd0;
                    winner_d   = W_NONE;
                    state_d    = S_INTRO;
                end else if (bus.btn_mode) begin
                    mode_ai_d = ~mode_ai_q;
                end
            end
            S_INTRO: begin
                if (bus.btn_start || w_timer_done) begin
                    state_d = mode_ai_q ? S_PVAI : S_PVP;
                end
            end
            S_PVP, S_PVAI: begin
                // A loss by one player is a round win for the other.
                if (bus.p1_out && bus.p2_out) begin
                    round_reset_d = 1'b1;
                end else if (bus.p1_out) begin
                    p2_score_d = w_p2_inc;
                    if (w_p2_inc == c_WIN) begin
                        state_d  = S_GAME_OVER;
                        winner_d = W_P2;
                    end else begin
                        round_reset_d = 1'b1;
                    end
                end else if (bus.p2_out) begin
                    p1_score_d = w_p1_inc;
                    if (w_p1_inc == c_WIN) begin
                        state_d  = S_GAME_OVER;
                        winner_d = W_P1;
                    end else begin
                        round_reset_d = 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (bus.btn_start || w_timer_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        state_enter_d = (state_d != state_q);
        if (state_enter_d && is_play_state(state_d)) begin
            round_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            mode_ai_q      <= 1'b0;
            p1_score_q     <= 2'd0;
            p2_score_q     <= 2'd0;
            winner_q       <= W_NONE;
            state_enter_q  <= 1'b0;
            round_reset_q  <= 1'b0;
            round_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_ai_q      <= mode_ai_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            winner_q       <= winner_d;
            state_enter_q  <= state_enter_d;
            round_reset_q  <= round_reset_d;
            round_active_q <= is_play_state(state_d);
        end
    end

    assign bus.game_state   = state_q;
    assign bus.mode_ai      = mode_ai_q;
    assign bus.state_enter  = state_enter_q;
    assign bus.round_reset  = round_reset_q;
    assign bus.round_active = round_active_q;
    assign bus.p1_score     = p1_score_q;
    assign bus.p2_score     = p2_score_q;
    assign bus.winner       = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_ctrl
// Brief    : Directed bench for game_flow_ctrl with a cycle-level match model.
// Revision : 1.0
// ============================================================================
module tb_game_flow_ctrl;

    localparam int INTRO_T = 150;
    localparam int OVER_T  = 300;
    localparam int WIN_R   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .INTRO_TICKS (INTRO_T),
        .OVER_TICKS  (OVER_T),
        .WIN_ROUNDS  (WIN_R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Match model: state number, scores, winner, pulses, frames seen in state.
    int m_state, m_mode, m_p1, m_p2, m_win, m_enter, m_rr, m_frames;

    always @(posedge clk) begin
        int nxt;
        int rr;
        if (reset) begin
            m_state = 0; m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
            m_enter = 0; m_rr = 0; m_frames = 0;
        end else begin
            nxt = m_state;
            rr  = 0;
            if (m_state == 0) begin
                if (bus.btn_start) begin
                    m_p1 = 0; m_p2 = 0; m_win = 0; nxt = 1;
                end else if (bus.btn_mode) begin
                    m_mode = 1 - m_mode;
                end
            end else if (m_state == 1) begin
                if (bus.btn_start || (bus.frame_tick && m_frames + 1 == INTRO_T))
                    nxt = m_mode ? 3 : 2;
            end else if (m_state == 2 || m_state == 3) begin
                if (bus.p1_out && bus.p2_out) rr = 1;
                else if (bus.p1_out) begin
                    m_p2 = m_p2 + 1;
                    if (m_p2 == WIN_R) begin nxt = 4; m_win = 2; end else rr = 1;
                end else if (bus.p2_out) begin
                    m_p1 = m_p1 + 1;
                    if (m_p1 == WIN_R) begin nxt = 4; m_win = 1; end else rr = 1;
                end
            end else begin
                if (bus.btn_start || (bus.frame_tick && m_frames + 1 == OVER_T))
                    nxt = 0;
            end
            m_enter  = (nxt != m_state) ? 1 : 0;
            if (m_enter == 1 && (nxt == 2 || nxt == 3)) rr = 1;
            m_rr     = rr;
            m_frames = m_enter ? 0 : m_frames + int'(bus.frame_tick);
            m_state  = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_state",  int'(bus.game_state),   m_state);
            chk("cyc_mode",   int'(bus.mode_ai),      m_mode);
            chk("cyc_enter",  int'(bus.state_enter),  m_enter);
            chk("cyc_rreset", int'(bus.round_reset),  m_rr);
            chk("cyc_active", int'(bus.round_active), (m_state == 2 || m_state == 3) ? 1 : 0);
            chk("cyc_p1",     int'(bus.p1_score),     m_p1);
            chk("cyc_p2",     int'(bus.p2_score),     m_p2);
            chk("cyc_winner", int'(bus.winner),       m_win);
        end
    end

    // Drive one cycle of inputs (called away from the clock edge), return at edge+1.
    task automatic apply(input bit st, input bit md, input bit tk,
                         input bit a, input bit b, input bit rs);
        bus.btn_start  = st;
        bus.btn_mode   = md;
        bus.frame_tick = tk;
        bus.p1_out     = a;
        bus.p2_out     = b;
        reset          = rs;
        @(posedge clk);
        #1;
        bus.btn_start = 0; bus.btn_mode = 0; bus.frame_tick = 0;
        bus.p1_out = 0; bus.p2_out = 0; reset = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            apply(0, 0, 1, 0, 0, 0);
            idle(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_start = 0; bus.btn_mode = 0; bus.frame_tick = 0;
        bus.p1_out = 0; bus.p2_out = 0;
        #2;
        apply(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        apply(0, 0, 0, 0, 0, 1);
        chk("rst_state", int'(bus.game_state), 0);
        chk("rst_enter", int'(bus.state_enter), 0);

        // Mode x3 then start: PvAI via full intro.
        for (int i = 0; i < 3; i++) begin apply(0, 1, 0, 0, 0, 0); idle(1); end
        chk("mode_x3", int'(bus.mode_ai), 1);
        apply(1, 0, 0, 0, 0, 0);
        chk("intro_state", int'(bus.game_state), 1);
        chk("intro_enter", int'(bus.state_enter), 1);
        ticks(INTRO_T - 1);
        chk("intro_149", int'(bus.game_state), 1);
        apply(0, 0, 1, 0, 0, 0);
        chk("pvai_state", int'(bus.game_state), 3);
        chk("pvai_rreset", int'(bus.round_reset), 1);
        idle(2);
        apply(0, 1, 0, 0, 0, 0);
        chk("pvai_mode_frozen", int'(bus.mode_ai), 1);
        apply(0, 0, 0, 0, 1, 0); idle(1);
        apply(0, 0, 0, 0, 1, 0); idle(1);
        chk("pvai_p1_2", int'(bus.p1_score), 2);

        // Reset mid-match, then stray p1_out in IDLE.
        apply(0, 0, 0, 0, 0, 1);
        chk("abort_state", int'(bus.game_state), 0);
        chk("abort_p1", int'(bus.p1_score), 0);
        chk("abort_mode", int'(bus.mode_ai), 0);
        apply(0, 0, 0, 1, 0, 0);
        chk("idle_p2_stray", int'(bus.p2_score), 0);

        // PvP with intro skipped; draw; P1 wins on three p2_out.
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("pvp_state", int'(bus.game_state), 2);
        idle(1);
        apply(0, 0, 0, 1, 1, 0);
        chk("draw_rreset", int'(bus.round_reset), 1);
        chk("draw_p1", int'(bus.p1_score), 0);
        for (int i = 1; i <= 3; i++) begin
            apply(0, 0, 0, 0, 1, 0);
            chk("p1_score_step", int'(bus.p1_score), i);
            chk("score_rreset", int'(bus.round_reset), (i < 3) ? 1 : 0);
            ticks(1);
        end
        chk("over_state", int'(bus.game_state), 4);
        chk("over_winner", int'(bus.winner), 1);

        // Automatic return: one frame has already elapsed in GAME_OVER.
        ticks(OVER_T - 2);
        chk("over_299", int'(bus.game_state), 4);
        apply(0, 0, 1, 0, 0, 0);
        chk("over_to_idle", int'(bus.game_state), 0);
        chk("idle_keeps_win", int'(bus.winner), 1);

        // Start+mode together; P2 wins; start leaves GAME_OVER at once.
        apply(1, 1, 0, 0, 0, 0);
        chk("start_mode_state", int'(bus.game_state), 1);
        chk("start_mode_mode", int'(bus.mode_ai), 0);
        chk("start_clears_win", int'(bus.winner), 0);
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin apply(0, 0, 0, 1, 0, 0); idle(1); end
        chk("p2_wins", int'(bus.winner), 2);
        apply(1, 0, 0, 0, 0, 0);
        chk("btn_over_idle", int'(bus.game_state), 0);
        chk("btn_over_mode", int'(bus.mode_ai), 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
